// File: rtl/mont_mul_iter_if.sv
// Operand/result handshake bundle for mont_mul_iter.
// master drives operands and result-ready; slave (the multiplier) drives the rest.
interface mont_mul_iter_if #(parameter int WIDTH = 256);
  logic             i_valid;
  logic             i_ready;
  logic [WIDTH-1:0] i_a;
  logic [WIDTH-1:0] i_b;
  logic [WIDTH-1:0] i_m;
  logic             o_valid;
  logic             o_ready;
  logic [WIDTH-1:0] o_data;

  modport master (
    output i_valid, i_a, i_b, i_m, o_ready,
    input  i_ready, o_valid, o_data
  );

  modport slave (
    input  i_valid, i_a, i_b, i_m, o_ready,
    output i_ready, o_valid, o_data
  );
endinterface

// File: rtl/mont_mul_iter.sv
// Iterative radix-2 Montgomery multiplier: o_data = A*B*2^-WIDTH mod M, one bit of A per cycle.
// Define MONTMUL_BACK_TO_BACK_EN to let DONE hand straight over to a new job on the same edge.
module mont_mul_iter #(
  parameter int WIDTH = 256
) (
  input  logic           clk,
  input  logic           rst,
  mont_mul_iter_if.slave bus
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, LOOP, REDUCE, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_q, b_q, m_q;
  logic [WIDTH+1:0] r_q, m_ext, t_add_b, t_add_m, r_nxt;
  logic [CNT_W-1:0] cnt_q;
  logic             load;
  logic             o_hs;

  assign m_ext = {2'b00, m_q};
  assign o_hs  = (state == DONE) && bus.o_ready;

  // One Montgomery step; R stays below 2M so WIDTH+2 bits never overflow.
  always_comb begin
    t_add_b = r_q + (a_q[0] ? {2'b00, b_q} : '0);
    t_add_m = t_add_b + (t_add_b[0] ? m_ext : '0);
    r_nxt   = t_add_m >> 1;
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_nxt   = state;
    bus.i_ready = 1'b0;
    load        = 1'b0;

    if (!rst) begin
      case (state)
        IDLE:    bus.i_ready = 1'b1;
`ifdef MONTMUL_BACK_TO_BACK_EN
        DONE:    bus.i_ready = bus.o_ready;
`endif
        default: bus.i_ready = 1'b0;
      endcase
    end
    load = bus.i_valid && bus.i_ready;

    case (state)
      IDLE:    if (load) state_nxt = LOOP;
      LOOP:    if (cnt_q == LAST) state_nxt = REDUCE;
      REDUCE:  state_nxt = DONE;
      DONE:    if (bus.o_ready) state_nxt = load ? LOOP : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses <= so every register samples pre-edge values.
    if (rst) begin
      state       <= IDLE;
      bus.o_valid <= 1'b0;
      bus.o_data  <= '0;
    end else begin
      state <= state_nxt;
      if (state == REDUCE) begin
        bus.o_valid <= 1'b1;
        bus.o_data  <= WIDTH'((r_q >= m_ext) ? r_q - m_ext : r_q);
      end else if (o_hs) begin
        bus.o_valid <= 1'b0;
      end
    end
  end

  // NOTE: datapath registers carry no reset; each job loads them before they are read.
  always_ff @(posedge clk) begin
    if (load) begin
      a_q   <= bus.i_a;
      b_q   <= bus.i_b;
      m_q   <= bus.i_m;
      r_q   <= '0;
      cnt_q <= '0;
    end else if (state == LOOP) begin
      a_q   <= a_q >> 1;
      r_q   <= r_nxt;
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_mont_mul_iter.sv
// Self-checking bench for mont_mul_iter at WIDTH=8: directed vectors plus a
// scoreboard built from plain modular arithmetic, checked every cycle.
module tb_mont_mul_iter;

  localparam int W = 8;
`ifdef MONTMUL_BACK_TO_BACK_EN
  localparam int PERIOD = W + 2;
`else
  localparam int PERIOD = W + 3;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mont_mul_iter_if #(.WIDTH(W)) bus ();
  mont_mul_iter #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // x such that x*2^W == A*B (mod M), found by search.
  function automatic int mont_ref(input int a, input int b, input int m);
    int ab;
    ab = (a * b) % m;
    for (int x = 0; x < m; x++)
      if (((x << W) % m) == ab) return x;
    return -1;
  endfunction

  typedef struct { int exp; int cyc; } job_t;
  job_t exp_q[$];
  int   acc_cyc_q[$];
  int   cyc = 0;
  int   hs_count = 0;
  logic prev_valid = 1'b0;
  logic prev_hs = 1'b0;
  logic prev_rst = 1'b1;
  logic [W-1:0] prev_data = '0;

  // Scoreboard and protocol monitor, sampled mid-cycle.
  always @(negedge clk) begin
    job_t j;
    cyc++;
    if (rst) begin
      exp_q.delete();
      check("i_ready_in_rst", bus.i_ready, 0);
    end else begin
      if (prev_rst) begin
        check("o_valid_after_rst", bus.o_valid, 0);
        check("i_ready_after_rst", bus.i_ready, 1);
      end
      if (bus.o_valid) begin
`ifdef MONTMUL_BACK_TO_BACK_EN
        check("i_ready_eq_o_ready_done", bus.i_ready, bus.o_ready);
`else
        check("i_ready_low_done", bus.i_ready, 0);
`endif
        if (prev_valid && !prev_hs) check("o_data_stable", bus.o_data, prev_data);
        if (!prev_valid) begin
          if (exp_q.size() == 0) check("o_valid_without_job", 1, 0);
          else check("latency", cyc - exp_q[0].cyc, W + 2);
        end
        if (bus.o_ready) begin
          hs_count++;
          if (exp_q.size() == 0) check("unexpected_output", 1, 0);
          else begin
            j = exp_q.pop_front();
            check("o_data_vs_model", bus.o_data, j.exp);
          end
        end
      end
      if (bus.i_valid && bus.i_ready) begin
        j.exp = mont_ref(int'(bus.i_a), int'(bus.i_b), int'(bus.i_m));
        j.cyc = cyc;
        exp_q.push_back(j);
        acc_cyc_q.push_back(cyc);
      end
    end
    prev_valid = bus.o_valid;
    prev_hs    = bus.o_valid && bus.o_ready;
    prev_data  = bus.o_data;
    prev_rst   = rst;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int a, input int b, input int m);
    bus.i_a     = W'(a);
    bus.i_b     = W'(b);
    bus.i_m     = W'(m);
    bus.i_valid = 1'b1;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (bus.i_ready) begin
        tick();
        bus.i_valid = 1'b0;
        return;
      end
    end
    check("send_timeout", 0, 1);
    tick();
    bus.i_valid = 1'b0;
  endtask

  task automatic wait_valid(output logic [W-1:0] d);
    d = 'x;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (bus.o_valid) begin
        d = bus.o_data;
        tick();
        return;
      end
    end
    check("o_valid_timeout", 0, 1);
    tick();
  endtask

  task automatic run_job(input string name, input int a, input int b, input int m, input int exp);
    logic [W-1:0] d;
    bus.o_ready = 1'b1;
    send(a, b, m);
    wait_valid(d);
    check(name, d, exp);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] d;
    int hs_before, k, a, b, m;

    bus.i_valid = 1'b0;
    bus.i_a     = '0;
    bus.i_b     = '0;
    bus.i_m     = '0;
    bus.o_ready = 1'b0;

    check("model_5_7_13", mont_ref(5, 7, 13), 1);
    check("model_200_200_255", mont_ref(200, 200, 255), 220);
    check("model_12_12_13", mont_ref(12, 12, 13), 3);
    check("model_1_1_13", mont_ref(1, 1, 13), 3);
    check("model_0_9_13", mont_ref(0, 9, 13), 0);

    rst = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    check("reset_o_valid", bus.o_valid, 0);
    check("reset_o_data", bus.o_data, 0);
    check("reset_i_ready", bus.i_ready, 0);
    tick();
    rst = 1'b0;
    tick();

    run_job("basic_5_7_13", 5, 7, 13, 1);
    run_job("r1_200_200_255", 200, 200, 255, 220);
    run_job("r1_12_12_13", 12, 12, 13, 3);
    run_job("zero_a", 0, 9, 13, 0);
    run_job("identity_1_1_13", 1, 1, 13, 3);
    run_job("max_254_254_255", 254, 254, 255, 1);
    run_job("small_m_3", 2, 2, 3, 1);

    // Backpressure: result held five cycles, then exactly one handshake.
    bus.o_ready = 1'b0;
    send(200, 200, 255);
    wait_valid(d);
    check("bp_first_data", d, 220);
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      check("bp_o_valid_held", bus.o_valid, 1);
      check("bp_o_data_held", bus.o_data, 220);
      check("bp_i_ready_low", bus.i_ready, 0);
      tick();
    end
    bus.o_ready = 1'b1;
    hs_before = hs_count;
    tick();
    @(negedge clk);
    check("bp_one_handshake", hs_count - hs_before, 1);
    check("bp_o_valid_dropped", bus.o_valid, 0);
    check("bp_i_ready_back", bus.i_ready, 1);
    tick();

    // Reset during LOOP cycle 4 discards the job.
    send(5, 7, 13);
    repeat (4) tick();
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_i_ready", bus.i_ready, 0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_o_valid", bus.o_valid, 0);
    check("mid_rst_i_ready_after", bus.i_ready, 1);
    tick();
    run_job("after_rst_5_7_13", 5, 7, 13, 1);

    // Streaming: i_valid held high, consumer always ready.
    acc_cyc_q.delete();
    bus.o_ready = 1'b1;
    bus.i_a     = W'(5);
    bus.i_b     = W'(7);
    bus.i_m     = W'(13);
    bus.i_valid = 1'b1;
    k = 0;
    while (acc_cyc_q.size() < 5 && k < 100) begin
      tick();
      k++;
    end
    bus.i_valid = 1'b0;
    check("stream_jobs_accepted", acc_cyc_q.size(), 5);
    for (int i = 1; i < acc_cyc_q.size(); i++)
      check("stream_period", acc_cyc_q[i] - acc_cyc_q[i-1], PERIOD);
    repeat (2 * W + 10) tick();

    // Random odd moduli with short random backpressure; the monitor checks every result.
    for (int n = 0; n < 200; n++) begin
      m = 2 * $urandom_range(1, 127) + 1;
      a = $urandom_range(0, m - 1);
      b = $urandom_range(0, m - 1);
      bus.o_ready = 1'b0;
      send(a, b, m);
      wait_valid(d);
      repeat ($urandom_range(0, 3)) tick();
      bus.o_ready = 1'b1;
      tick();
    end
    repeat (5) tick();

    check("scoreboard_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
